// File: rtl/mobius_seq_ctrl.sv
// Sequencer for the external single-layer Mobius round datapath (butterfly + perfect shuffle).
// Latency: accept at edge t, out_valid from edge t+LOG2_N; minimum job period LOG2_N+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready   input handshake, in_data is the truth table (index 0 = f(0))
//   rnd_in / rnd_out    state register to the round datapath / its combinational result
//   out_valid/out_ready output handshake, out_data carries the ANF coefficients
//   busy, round_idx     high while rounds run / rounds completed in the current job
//   abort               only with MOBIUS_ABORT_EN defined: drops the job in RUN or DONE
//
// Optional feature macro: MOBIUS_ABORT_EN (adds the abort input).

module mobius_seq_ctrl #(
    parameter int N      = 256,
    parameter int LOG2_N = 8,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MOBIUS_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:N-1]     in_data,
    output logic [0:N-1]     rnd_in,
    input  logic [0:N-1]     rnd_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:N-1]     out_data,
    output logic             busy,
    output logic [CNT_W-1:0] round_idx
);

    // Parameter sanity, checked at elaboration.
    generate
        if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
            $error("mobius_seq_ctrl: N must be a power of two >= 2");
        end
        if ((1 << LOG2_N) != N) begin : g_bad_log2
            $error("mobius_seq_ctrl: LOG2_N must equal log2(N)");
        end
        if ((1 << CNT_W) <= LOG2_N) begin : g_bad_cnt
            $error("mobius_seq_ctrl: CNT_W too narrow to reach LOG2_N");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the round whose result is captured on the edge that enters DONE.
    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(LOG2_N - 1);

    state_t           state;
    state_t           state_nxt;
    logic [0:N-1]     sreg;
    logic [CNT_W-1:0] rnd_cnt;
    logic             kill;

    // kill drops the job in RUN/DONE; it outranks round completion and out_ready.
`ifdef MOBIUS_ABORT_EN
    assign kill = abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (rnd_cnt == LAST_RND) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (kill) begin
            state_nxt = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == RUN);
        out_valid = (state == DONE);
    end

    // ------------------------------------------------------------------
    // Datapath: state register and round counter
    // ------------------------------------------------------------------
    // In RUN the register captures one round per cycle; the counter saturates
    // at LOG2_N naturally because RUN is left on the same edge it reaches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            rnd_cnt <= '0;
        end else if (kill) begin
            sreg    <= '0;
            rnd_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg    <= in_data;
                        rnd_cnt <= '0;
                    end
                end
                RUN: begin
                    sreg    <= rnd_out;
                    rnd_cnt <= rnd_cnt + CNT_W'(1);
                end
                default: begin
                    // DONE: hold result and count until handoff.
                end
            endcase
        end
    end

    assign rnd_in    = sreg;
    assign out_data  = sreg;
    assign round_idx = rnd_cnt;

`ifndef SYNTHESIS
    // The offered result must not move while the consumer stalls.
    out_data_hold_a: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (!out_valid || $stable(out_data)))
        else $error("mobius_seq_ctrl: out_data changed under backpressure");
`endif

endmodule

// File: tb/tb_mobius_seq_ctrl.sv
module tb_mobius_seq_ctrl;

    localparam int N      = 8;
    localparam int LOG2_N = 3;
    localparam int CNT_W  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [0:N-1]     in_data;
    logic [0:N-1]     rnd_in;
    logic [0:N-1]     rnd_out;
    logic             out_valid;
    logic             out_ready;
    logic [0:N-1]     out_data;
    logic             busy;
    logic [CNT_W-1:0] round_idx;
`ifdef MOBIUS_ABORT_EN
    logic             abort;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mobius_seq_ctrl #(.N(N), .LOG2_N(LOG2_N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MOBIUS_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rnd_in    (rnd_in),
        .rnd_out   (rnd_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_idx (round_idx)
    );

    // Round datapath model: butterfly on index bit 0, then rotate the index left by one.
    function automatic logic [0:N-1] round_fn(input logic [0:N-1] x);
        logic [0:N-1] y;
        logic [0:N-1] z;
        int j;
        for (int k = 0; k < N / 2; k++) begin
            y[2*k]   = x[2*k];
            y[2*k+1] = x[2*k] ^ x[2*k+1];
        end
        z = '0;
        for (int p = 0; p < N; p++) begin
            j = ((p << 1) | (p >> (LOG2_N - 1))) & (N - 1);
            z[j] = y[p];
        end
        return z;
    endfunction

    assign rnd_out = round_fn(rnd_in);

    typedef struct {
        logic [0:N-1] din;
        logic [0:N-1] exp;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for out_valid; an expired budget counts as a failure.
    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("wait_out_valid", 32'(out_valid), 32'd1);
    endtask

    // Full job with per-cycle checks of busy / round_idx and the final result.
    task automatic run_job(input logic [0:N-1] din, input logic [0:N-1] exp, output logic [0:N-1] got);
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        in_data  = din;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h3C;  // must not affect the running job
        for (int r = 0; r < LOG2_N; r++) begin
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_round_idx", 32'(round_idx), 32'(r));
            chk("run_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_round_idx", 32'(round_idx), 32'(LOG2_N));
        chk("done_out_data", 32'(out_data), 32'(exp));
        got = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("handoff_in_ready", 32'(in_ready), 32'd1);
        chk("handoff_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [0:N-1] got;
        logic [0:N-1] first;
        logic [0:N-1] outs[2];
        int acc_cyc[2];
        int nacc;
        int nout;
        int seen_valid;
        logic acc;

        tbl[0] = '{din: 8'b1000_0000, exp: 8'b1111_1111};
        tbl[1] = '{din: 8'b1111_1111, exp: 8'b1000_0000};
        tbl[2] = '{din: 8'b0000_0001, exp: 8'b0000_0001};
        tbl[3] = '{din: 8'b0101_0101, exp: 8'b0100_0000};
        tbl[4] = '{din: 8'b0000_0000, exp: 8'b0000_0000};
        tbl[5] = '{din: 8'b0110_1001, exp: 8'b0110_1000};
        tbl[6] = '{din: 8'b1100_0000, exp: 8'b1010_1010};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef MOBIUS_ABORT_EN
        abort     = 1'b0;
`endif
        #23;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_round_idx", 32'(round_idx), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven transforms.
        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i].din, tbl[i].exp, got);
        end

        // Involution: transform the result of 0xFF again.
        run_job(8'b1111_1111, 8'b1000_0000, first);
        run_job(first, 8'b1111_1111, got);

        // Backpressure for 10 cycles, with in_valid ignored in DONE.
        in_data  = 8'b0101_0101;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'h40);
            chk("bp_round_idx", 32'(round_idx), 32'(LOG2_N));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Back-to-back jobs with in_valid held and out_ready tied high.
        in_data   = 8'b1100_0000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        nacc = 0;
        nout = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        outs[0] = '0;
        outs[1] = '0;
        for (int c = 0; c < 20; c++) begin
            acc = in_valid && in_ready;
            if (acc) acc_cyc[nacc] = c;
            if (out_valid && nout < 2) begin
                outs[nout] = out_data;
                nout++;
            end
            tick();
            if (acc) begin
                nacc++;
                in_data = (nacc == 1) ? 8'b0110_1001 : 8'h5A;
                if (nacc == 2) in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd2);
        chk("b2b_period", 32'(acc_cyc[1] - acc_cyc[0]), 32'(LOG2_N + 2));
        chk("b2b_outputs", 32'(nout), 32'd2);
        chk("b2b_result0", 32'(outs[0]), 32'hAA);
        chk("b2b_result1", 32'(outs[1]), 32'h68);

        // Asynchronous reset in RUN with round_idx == 1.
        in_data  = 8'b1000_0000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_round_idx", 32'(round_idx), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_round_idx", 32'(round_idx), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        seen_valid = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid) seen_valid++;
        end
        out_ready = 1'b0;
        chk("arst_no_late_valid", 32'(seen_valid), 32'd0);

`ifdef MOBIUS_ABORT_EN
        // Abort on the cycle that would complete the last round.
        in_data  = 8'b1000_0000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("ab_run_idx", 32'(round_idx), 32'(LOG2_N - 1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_run_in_ready", 32'(in_ready), 32'd1);
        chk("ab_run_out_valid", 32'(out_valid), 32'd0);
        chk("ab_run_round_idx", 32'(round_idx), 32'd0);
        chk("ab_run_out_data", 32'(out_data), 32'd0);

        // Abort together with out_ready in DONE.
        in_data  = 8'b1111_1111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out();
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("ab_done_in_ready", 32'(in_ready), 32'd1);
        chk("ab_done_out_data", 32'(out_data), 32'd0);

        // Abort in IDLE does not block an accept.
        abort    = 1'b1;
        in_data  = 8'b0000_0001;
        in_valid = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("ab_idle_busy", 32'(busy), 32'd1);
        wait_out();
        chk("ab_idle_result", 32'(out_data), 32'h01);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mobius_seq_ctrl.md
Name: mobius_seq_ctrl

Overview:
- Sequencer for the single-layer Mobius round datapath (butterfly + perfect shuffle, N bits wide).
- Accepts an N-bit truth table over a valid/ready handshake and holds it in a state register. It feeds the register to the external round datapath for exactly LOG2_N cycles, then presents the ANF result over a valid/ready handshake with backpressure.
- Replaces the free-running, reset-less init/counter scheme with an explicit restartable FSM, so back-to-back transforms are possible.

Parameters:
N, 256, transform width in bits; power of two, >= 2
LOG2_N, 8, number of rounds; must equal log2(N)
CNT_W, 4, round counter width; must satisfy 2**CNT_W > LOG2_N

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data is valid
in_ready  output  1  controller can accept a new vector
in_data  input  [0:N-1]  truth table, index 0 = f(0)
rnd_in  output  [0:N-1]  state register, drives round datapath input
rnd_out  input  [0:N-1]  round datapath output (combinational from rnd_in)
out_valid  output  1  out_data holds a finished transform
out_ready  input  1  consumer accepts out_data
out_data  output  [0:N-1]  ANF coefficients; equals state register
busy  output  1  high in RUN
round_idx  output  [CNT_W-1:0]  rounds completed in current job

Behaviour:
- Reset is asynchronous and active-high. On rst, state=IDLE, state reg=0, round_idx=0, in_ready=1, out_valid=0, busy=0.
- FSM states: IDLE, RUN, DONE. Outputs are Moore: in_ready=(IDLE), busy=(RUN), out_valid=(DONE).
- IDLE:
  - On in_valid & in_ready, state reg <= in_data, round_idx <= 0, go to RUN.
  - Otherwise hold all state.
- RUN, each cycle:
  - state reg <= rnd_out, round_idx <= round_idx+1.
  - When round_idx == LOG2_N-1 (last round being captured), go to DONE.
- DONE:
  - state reg and round_idx (= LOG2_N) hold.
  - On out_ready, go to IDLE.
  - in_ready stays low in DONE; a new vector cannot be accepted in the same cycle as the handoff.
- Latency: accept edge at cycle t; DONE is entered at edge t+LOG2_N; out_valid is visible from cycle t+LOG2_N. Minimum job period is LOG2_N+2 cycles.
- Inputs are ignored outside their accepting state:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside DONE.
  - in_data is sampled only on the accept edge; later changes have no effect.
- out_data is stable while out_valid=1 and out_ready=0. Backpressure for any number of cycles must not corrupt the result.
- LOG2_N=1 boundary: RUN lasts exactly one cycle.
- round_idx never exceeds LOG2_N and does not wrap.
- Reset asserted mid-RUN or mid-DONE: all state returns to reset values immediately; the partial result is discarded and no out_valid pulse is produced.
- Simulation-only check (excluded from synthesis): flag an error if out_data changes while out_valid & ~out_ready.

Optional Feature:
- Macro: MOBIUS_ABORT_EN.
- When defined, an extra input port abort (1 bit) is added.
  - abort=1 in RUN or DONE: next edge goes to IDLE, round_idx <= 0, state reg cleared to 0; no out_valid for the aborted job.
  - abort has priority over round completion and over out_ready in the same cycle.
  - abort in IDLE has no effect; in_valid is still accepted that cycle.
- When undefined, the port is absent and behaviour is exactly as above.

Test Plan:
- N=8, LOG2_N=3: reset, then in_data=8'b1000_0000 accepted -> busy high 3 cycles, round_idx 0,1,2,3; out_valid at accept+3 with out_data=8'b1111_1111.
- N=8: in_data=8'b1111_1111 -> out_data=8'b1000_0000. Then feed that result back as a new job -> 8'b1111_1111 (involution check).
- Backpressure: out_ready held 0 for 10 cycles after out_valid -> out_data and round_idx=3 stable, in_ready=0. Then out_ready=1 for one cycle -> IDLE, in_ready=1 next cycle.
- Back-to-back: in_valid held 1 with two vectors, out_ready tied 1 -> second accept exactly LOG2_N+2 cycles after the first; in_valid during RUN/DONE ignored; both results correct.
- Reset mid-job: rst pulse asynchronous to clk during RUN with round_idx=1 -> immediate IDLE, out_valid=0, round_idx=0, no later out_valid.
- With MOBIUS_ABORT_EN: abort in the RUN cycle that would complete -> IDLE, no out_valid. abort together with out_ready in DONE -> IDLE, state reg 0.
